// File: rtl/issue_rf_stage_buf_pkg.sv
// Shared definitions for the issue -> register-read staging buffer.
//   DEF_UOP_W   : default width of one lane's uop payload
//   DEF_PADDR_W : default physical register address width
//   skidState_e : occupancy of the main/skid register pair
package issue_rf_stage_buf_pkg;

   localparam int DEF_UOP_W   = 128;
   localparam int DEF_PADDR_W = 6;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skidState_e;

endpackage

// File: rtl/issue_rf_skid_entry.sv
// One multi-lane register bank (valid bits, uop payloads, two source
// addresses). Used twice by the staging buffer: once as the main entry
// that drives the outputs, once as the skid entry.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   load, clear       load dValid/dUop/dOp0/dOp1; clear wins over load
//   dValid..dOp1      incoming group
//   qValid..qOp1      stored group; invalid lanes hold zero payload/address
module issue_rf_skid_entry
   import issue_rf_stage_buf_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int UOP_W   = DEF_UOP_W,
   parameter int PADDR_W = DEF_PADDR_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic                       clear,
   input  logic [LANES-1:0]           dValid,
   input  logic [LANES*UOP_W-1:0]     dUop,
   input  logic [LANES*PADDR_W-1:0]   dOp0,
   input  logic [LANES*PADDR_W-1:0]   dOp1,
   output logic [LANES-1:0]           qValid,
   output logic [LANES*UOP_W-1:0]     qUop,
   output logic [LANES*PADDR_W-1:0]   qOp0,
   output logic [LANES*PADDR_W-1:0]   qOp1
);

   logic [LANES*UOP_W-1:0]   maskUop;
   logic [LANES*PADDR_W-1:0] maskOp0;
   logic [LANES*PADDR_W-1:0] maskOp1;

   // Invalid lanes are zeroed on capture so the outputs never leak stale
   // or garbage payload on lanes the issue side did not fill.
   always_comb begin
      maskUop = '0;
      maskOp0 = '0;
      maskOp1 = '0;
      for (int i = 0; i < LANES; i++) begin
         if (dValid[i]) begin
            maskUop[i*UOP_W +: UOP_W]     = dUop[i*UOP_W +: UOP_W];
            maskOp0[i*PADDR_W +: PADDR_W] = dOp0[i*PADDR_W +: PADDR_W];
            maskOp1[i*PADDR_W +: PADDR_W] = dOp1[i*PADDR_W +: PADDR_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qValid <= '0;
         qUop   <= '0;
         qOp0   <= '0;
         qOp1   <= '0;
      end else if (clear) begin
         qValid <= '0;
         qUop   <= '0;
         qOp0   <= '0;
         qOp1   <= '0;
      end else if (load) begin
         qValid <= dValid;
         qUop   <= maskUop;
         qOp0   <= maskOp0;
         qOp1   <= maskOp1;
      end
   end

endmodule

// File: rtl/issue_rf_stage_buf.sv
// Multi-lane issue -> register-read staging buffer with a 2-deep skid.
// LANES uops move together as one group under a valid/ready handshake;
// in_ready is a flop so downstream backpressure never reaches issue
// combinationally. Outputs come straight from the main entry flops.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   flush                    drop everything held and any group offered
//   pause, prim_pause_req    hold the output (either one)
//   in_valid/in_uop/in_op*   group from issue; in_ready = skid empty
//   out_valid/out_uop        group to register-read; out_ready accepts
//   prf_rs0/prf_rs1          registered PRF read addresses per lane
//   stall_cnt                saturating count of stalled output cycles
module issue_rf_stage_buf
   import issue_rf_stage_buf_pkg::*;
#(
   parameter int LANES   = 2,
   parameter int UOP_W   = DEF_UOP_W,
   parameter int PADDR_W = DEF_PADDR_W,
   parameter int CNT_W   = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       pause,
   input  logic                       prim_pause_req,
   input  logic [LANES-1:0]           in_valid,
   input  logic [LANES*UOP_W-1:0]     in_uop,
   input  logic [LANES*PADDR_W-1:0]   in_op0_paddr,
   input  logic [LANES*PADDR_W-1:0]   in_op1_paddr,
   output logic                       in_ready,
   output logic [LANES-1:0]           out_valid,
   output logic [LANES*UOP_W-1:0]     out_uop,
   output logic [LANES*PADDR_W-1:0]   prf_rs0,
   output logic [LANES*PADDR_W-1:0]   prf_rs1,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   skidState_e state;
   skidState_e nextState;

   logic hold;
   logic inFire;
   logic outFire;
   logic stallNow;

   logic mainLoad;
   logic mainFromSkid;
   logic mainClear;
   logic skidLoad;
   logic skidClear;

   logic [LANES-1:0]         skidValid;
   logic [LANES*UOP_W-1:0]   skidUop;
   logic [LANES*PADDR_W-1:0] skidOp0;
   logic [LANES*PADDR_W-1:0] skidOp1;

   logic [LANES-1:0]         mainDValid;
   logic [LANES*UOP_W-1:0]   mainDUop;
   logic [LANES*PADDR_W-1:0] mainDOp0;
   logic [LANES*PADDR_W-1:0] mainDOp1;

   assign hold    = pause | prim_pause_req;
   assign inFire  = (|in_valid) & in_ready;
   assign outFire = (|out_valid) & out_ready & ~hold;
   assign stallNow = (|out_valid) & ~outFire & ~flush;

   // Main refills from the skid when draining TWO so acceptance order holds.
   assign mainDValid = mainFromSkid ? skidValid : in_valid;
   assign mainDUop   = mainFromSkid ? skidUop   : in_uop;
   assign mainDOp0   = mainFromSkid ? skidOp0   : in_op0_paddr;
   assign mainDOp1   = mainFromSkid ? skidOp1   : in_op1_paddr;

   issue_rf_skid_entry #(
      .LANES   (LANES),
      .UOP_W   (UOP_W),
      .PADDR_W (PADDR_W)
   ) mainEntry (
      .clk    (clk),
      .rst    (rst),
      .load   (mainLoad),
      .clear  (mainClear),
      .dValid (mainDValid),
      .dUop   (mainDUop),
      .dOp0   (mainDOp0),
      .dOp1   (mainDOp1),
      .qValid (out_valid),
      .qUop   (out_uop),
      .qOp0   (prf_rs0),
      .qOp1   (prf_rs1)
   );

   issue_rf_skid_entry #(
      .LANES   (LANES),
      .UOP_W   (UOP_W),
      .PADDR_W (PADDR_W)
   ) skidEntry (
      .clk    (clk),
      .rst    (rst),
      .load   (skidLoad),
      .clear  (skidClear),
      .dValid (in_valid),
      .dUop   (in_uop),
      .dOp0   (in_op0_paddr),
      .dOp1   (in_op1_paddr),
      .qValid (skidValid),
      .qUop   (skidUop),
      .qOp0   (skidOp0),
      .qOp1   (skidOp1)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= EMPTY;
         in_ready <= 1'b0;
      end else begin
         state    <= nextState;
         in_ready <= (nextState != TWO);
      end
   end

   // Flush overrides everything, including a same-cycle in_fire.
   always_comb begin
      nextState    = state;
      mainLoad     = 1'b0;
      mainFromSkid = 1'b0;
      mainClear    = 1'b0;
      skidLoad     = 1'b0;
      skidClear    = 1'b0;
      if (flush) begin
         nextState = EMPTY;
         mainClear = 1'b1;
         skidClear = 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (inFire) begin
                  mainLoad  = 1'b1;
                  nextState = ONE;
               end
            end
            ONE: begin
               if (outFire && inFire) begin
                  mainLoad = 1'b1;
               end else if (outFire) begin
                  mainClear = 1'b1;
                  nextState = EMPTY;
               end else if (inFire) begin
                  skidLoad  = 1'b1;
                  nextState = TWO;
               end
            end
            TWO: begin
               if (outFire) begin
                  mainLoad     = 1'b1;
                  mainFromSkid = 1'b1;
                  skidClear    = 1'b1;
                  nextState    = ONE;
               end
            end
            default: begin
               nextState = EMPTY;
               mainClear = 1'b1;
               skidClear = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (stallNow && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_issue_rf_stage_buf.sv
module tb_issue_rf_stage_buf;

   localparam int LANES   = 2;
   localparam int UOP_W   = 16;
   localparam int PADDR_W = 6;
   localparam int CNT_W   = 4;

   logic                     clk;
   logic                     rst;
   logic                     flush;
   logic                     pause;
   logic                     prim_pause_req;
   logic [LANES-1:0]         in_valid;
   logic [LANES*UOP_W-1:0]   in_uop;
   logic [LANES*PADDR_W-1:0] in_op0_paddr;
   logic [LANES*PADDR_W-1:0] in_op1_paddr;
   logic                     in_ready;
   logic [LANES-1:0]         out_valid;
   logic [LANES*UOP_W-1:0]   out_uop;
   logic [LANES*PADDR_W-1:0] prf_rs0;
   logic [LANES*PADDR_W-1:0] prf_rs1;
   logic                     out_ready;
   logic [CNT_W-1:0]         stall_cnt;

   issue_rf_stage_buf #(
      .LANES   (LANES),
      .UOP_W   (UOP_W),
      .PADDR_W (PADDR_W),
      .CNT_W   (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .pause          (pause),
      .prim_pause_req (prim_pause_req),
      .in_valid       (in_valid),
      .in_uop         (in_uop),
      .in_op0_paddr   (in_op0_paddr),
      .in_op1_paddr   (in_op1_paddr),
      .in_ready       (in_ready),
      .out_valid      (out_valid),
      .out_uop        (out_uop),
      .prf_rs0        (prf_rs0),
      .prf_rs1        (prf_rs1),
      .out_ready      (out_ready),
      .stall_cnt      (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: a FIFO of accepted groups, at most two deep.
   typedef struct {
      logic [LANES-1:0]         v;
      logic [LANES*UOP_W-1:0]   uop;
      logic [LANES*PADDR_W-1:0] op0;
      logic [LANES*PADDR_W-1:0] op1;
   } grp_t;

   grp_t q[$];
   logic mReady;
   int   mCnt;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         mReady = 1'b0;
         mCnt   = 0;
      end else begin
         automatic bit   hld  = pause || prim_pause_req;
         automatic bit   oF   = (q.size() > 0) && out_ready && !hld;
         automatic bit   iF   = (in_valid != 0) && mReady;
         automatic grp_t g;
         if (q.size() > 0 && !oF && !flush && mCnt < (1 << CNT_W) - 1) mCnt++;
         if (flush) begin
            q.delete();
         end else begin
            if (oF) void'(q.pop_front());
            if (iF) begin
               g.v = in_valid; g.uop = '0; g.op0 = '0; g.op1 = '0;
               for (int i = 0; i < LANES; i++) begin
                  if (in_valid[i]) begin
                     g.uop[i*UOP_W +: UOP_W]     = in_uop[i*UOP_W +: UOP_W];
                     g.op0[i*PADDR_W +: PADDR_W] = in_op0_paddr[i*PADDR_W +: PADDR_W];
                     g.op1[i*PADDR_W +: PADDR_W] = in_op1_paddr[i*PADDR_W +: PADDR_W];
                  end
               end
               q.push_back(g);
            end
         end
         mReady = (q.size() < 2);
      end
   end

   always @(negedge clk) begin
      automatic grp_t h;
      h.v = '0; h.uop = '0; h.op0 = '0; h.op1 = '0;
      if (q.size() > 0) h = q[0];
      chk("cmp_out_valid", 64'(out_valid), 64'(h.v));
      chk("cmp_out_uop",   64'(out_uop),   64'(h.uop));
      chk("cmp_prf_rs0",   64'(prf_rs0),   64'(h.op0));
      chk("cmp_prf_rs1",   64'(prf_rs1),   64'(h.op1));
      chk("cmp_in_ready",  64'(in_ready),  64'(mReady));
      chk("cmp_stall_cnt", 64'(stall_cnt), 64'(mCnt));
   end

   // Lane i: op0 = base+8i, op1 = base+1+8i, uop = {A0+i, base}.
   task automatic setIn(input logic [LANES-1:0] v, input int base);
      in_valid = v;
      for (int i = 0; i < LANES; i++) begin
         in_op0_paddr[i*PADDR_W +: PADDR_W] = PADDR_W'(base + 8*i);
         in_op1_paddr[i*PADDR_W +: PADDR_W] = PADDR_W'(base + 1 + 8*i);
         in_uop[i*UOP_W +: UOP_W]           = {8'(8'hA0 + i), 8'(base)};
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; pause = 1'b0; prim_pause_req = 1'b0;
      in_valid = '0; in_uop = '0; in_op0_paddr = '0; in_op1_paddr = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("lit_ready_after_reset", 64'(in_ready), 64'd1);

      // Streaming
      out_ready = 1'b1;
      setIn(2'b11, 3);
      @(negedge clk);
      chk("lit_stream_valid", 64'(out_valid), 64'd3);
      chk("lit_stream_rs0_a", 64'(prf_rs0[5:0]), 64'd3);
      setIn(2'b11, 5);
      @(negedge clk);
      chk("lit_stream_rs0_b", 64'(prf_rs0[5:0]), 64'd5);
      chk("lit_stream_rs1_b", 64'(prf_rs1[5:0]), 64'd6);
      setIn(2'b11, 7);
      @(negedge clk);
      in_valid = '0;
      @(negedge clk);
      chk("lit_stream_stall", 64'(stall_cnt), 64'd0);

      // Backpressure fill: A then B, C offered while full
      out_ready = 1'b0;
      setIn(2'b11, 10);
      @(negedge clk);
      setIn(2'b11, 20);
      @(negedge clk);
      chk("lit_bp_ready_low", 64'(in_ready), 64'd0);
      chk("lit_bp_a_out", 64'(prf_rs0[5:0]), 64'd10);
      setIn(2'b11, 30);
      @(negedge clk);
      in_valid = '0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("lit_bp_b_out", 64'(prf_rs0[5:0]), 64'd20);
      chk("lit_bp_ready_high", 64'(in_ready), 64'd1);
      chk("lit_bp_stall", 64'(stall_cnt), 64'd2);
      @(negedge clk);
      chk("lit_bp_drained", 64'(out_valid), 64'd0);

      // Partial lanes
      setIn(2'b10, 7);
      @(negedge clk);
      in_valid = '0;
      chk("lit_part_valid", 64'(out_valid), 64'd2);
      chk("lit_part_uop0", 64'(out_uop[15:0]), 64'd0);
      chk("lit_part_rs0_l0", 64'(prf_rs0[5:0]), 64'd0);
      chk("lit_part_rs0_l1", 64'(prf_rs0[11:6]), 64'd15);
      @(negedge clk);

      // Flush vs input (with hold also asserted)
      out_ready = 1'b0;
      setIn(2'b11, 12);
      @(negedge clk);
      setIn(2'b11, 22);
      @(negedge clk);
      setIn(2'b11, 40);
      flush = 1'b1;
      prim_pause_req = 1'b1;
      @(negedge clk);
      chk("lit_flush_valid", 64'(out_valid), 64'd0);
      chk("lit_flush_ready", 64'(in_ready), 64'd1);
      flush = 1'b0;
      prim_pause_req = 1'b0;
      in_valid = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);

      // Reset mid-traffic from TWO
      out_ready = 1'b0;
      setIn(2'b11, 1);
      @(negedge clk);
      setIn(2'b11, 2);
      @(negedge clk);
      in_valid = '0;
      @(negedge clk);
      chk("lit_rst_pre_two", 64'(in_ready), 64'd0);
      #2 rst = 1'b0;
      #1;
      chk("lit_rst_valid", 64'(out_valid), 64'd0);
      chk("lit_rst_rs0", 64'(prf_rs0), 64'd0);
      chk("lit_rst_stall", 64'(stall_cnt), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("lit_rst_ready", 64'(in_ready), 64'd1);

      // Pause and counter saturation
      out_ready = 1'b1;
      pause = 1'b1;
      setIn(2'b11, 33);
      @(negedge clk);
      in_valid = '0;
      repeat (20) @(negedge clk);
      chk("lit_pause_sat", 64'(stall_cnt), 64'd15);
      chk("lit_pause_hold", 64'(prf_rs0[5:0]), 64'd33);
      pause = 1'b0;
      @(negedge clk);
      chk("lit_pause_accept", 64'(out_valid), 64'd0);
      chk("lit_pause_cnt_kept", 64'(stall_cnt), 64'd15);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
